ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of the result and store-data paths.
REQ-002 SHALL have parameter PC_W, default 32: width of the program counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports stall and flush, inputs, 1 bit each: stall holds the stage; flush squashes the EX instruction.
REQ-006 SHALL have ports EXE_Result, input, DATA_W; EXE_Zero, input, 1; and Overflow, input, 1: the combinational ALU outputs.
REQ-007 SHALL have port ex_op, input, 5 bits: ALU operation code of the EX instruction.
REQ-008 SHALL have ports ex_valid, ex_reg_write, ex_fp_write, ex_mem_read, ex_mem_write and ex_trap_en, inputs, 1 bit each: EX instruction control.
REQ-009 SHALL have ports ex_rd, input, 5 bits: destination register; and ex_store_data, input, DATA_W: store data.
REQ-010 SHALL have port ex_branch, input, 2 bits: 00 none, 01 beq, 10 bne, 11 bc1t.
REQ-011 SHALL have ports ex_pc_plus4 and ex_branch_target, inputs, PC_W each.
REQ-012 SHALL have outputs MEM_Result and MEM_StoreData, DATA_W each; and MEM_Rd, 5 bits.
REQ-013 SHALL have outputs MEM_Valid, MEM_RegWrite, MEM_FpWrite, MEM_MemRead and MEM_MemWrite, 1 bit each.
REQ-014 SHALL have outputs branch_taken, 1 bit; and branch_pc, PC_W: registered branch redirect.
REQ-015 SHALL have outputs fp_cond, 1 bit: the FP condition flag.
REQ-016 SHALL have outputs exc_req, 1 bit; and epc, PC_W: overflow exception request and faulting PC.
REQ-017 SHALL have port exc_ack, input, 1 bit: acknowledgement of an exception by the controller.

Function
REQ-018 SHALL define "accept" as: no stall, no flush, state NORMAL and ex_valid=1; every accept SHALL register the EX instruction into the MEM outputs with 1-cycle latency.
REQ-019 SHALL hold all MEM outputs, fp_cond and the state unchanged on stall=1, with flush=0.
REQ-020 SHALL load a bubble on flush=1 or ex_valid=0 (with stall=0): MEM_Valid and all write/read enables 0; data fields don't-care; flush SHALL take priority over stall.
REQ-021 SHALL detect a trap when accepting with ex_trap_en=1, Overflow=1 and ex_op being 5'h3 or 5'h5.
REQ-022 SHALL on a trap: load a bubble, set epc=ex_pc_plus4-4 and move to state EXC_PENDING.
REQ-023 SHALL assert exc_req continuously in EXC_PENDING.
REQ-024 SHALL squash every incoming instruction to a bubble while in EXC_PENDING, leaving fp_cond and branch unaffected.
REQ-025 SHALL return from EXC_PENDING to NORMAL on the edge where exc_ack=1; exc_ack in NORMAL SHALL be ignored.
REQ-026 SHALL, when accepting ex_op in 5'h11..5'h15, load fp_cond with EXE_Zero; MEM_RegWrite for such ops SHALL follow ex_reg_write unchanged.
REQ-027 SHALL resolve a branch on accept: beq taken iff EXE_Zero=1; bne taken iff EXE_Zero=0; bc1t taken iff the registered fp_cond=1 before this edge.
REQ-028 SHALL register branch_taken and branch_pc=ex_branch_target on a taken branch; otherwise branch_taken=0 the next cycle (pulse, not sticky unless stalled).
REQ-029 SHALL never take a branch on a trapping or squashed instruction.
REQ-030 SHALL pass EXE_Result through at full DATA_W without modification, including ops 5'hf and 5'h10.

Reset
REQ-031 SHALL on rst=1, immediately and independent of clk, drive all MEM outputs, branch_taken, branch_pc, fp_cond, exc_req and epc to 0 and enter NORMAL.
REQ-032 SHALL have rst override stall, flush and exc_ack, including in the middle of EXC_PENDING.

Verification
REQ-033 SHALL be tested with: accept op 5'h3, EXE_Result=64'h5, ex_rd=9, ex_reg_write=1 -> next cycle MEM_Result=5, MEM_Rd=9, MEM_RegWrite=1, MEM_Valid=1.
REQ-034 SHALL be tested with: op 5'h5, ex_trap_en=1, Overflow=1, ex_pc_plus4=32'h104 -> MEM_Valid=0, exc_req=1, epc=32'h100; exc_req stays 1 over 3 cycles; exc_ack=1 -> exc_req=0 next cycle.
REQ-035 SHALL be tested with: op 5'h12 with EXE_Zero=1, then bc1t with target 32'h200 -> fp_cond=1, then branch_taken=1 and branch_pc=32'h200 for one cycle.
REQ-036 SHALL be tested with: stall=1 for 2 cycles with changing EX inputs -> MEM outputs constant; stall=1 with flush=1 -> bubble.
REQ-037 SHALL be tested with: beq with EXE_Zero=0 -> branch_taken=0; bne with EXE_Zero=0 -> branch_taken=1.
REQ-038 SHALL be tested with: rst asserted mid-clock in EXC_PENDING -> all outputs 0 before the next edge, state NORMAL.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX-side instruction bundle in, MEM-side pipeline register out
interface ex_mem_stage_if #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 32
);
    logic [DATA_W-1:0] EXE_Result;
    logic              EXE_Zero;
    logic              Overflow;
    logic [4:0]        ex_op;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_fp_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_trap_en;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_store_data;
    logic [1:0]        ex_branch;
    logic [PC_W-1:0]   ex_pc_plus4;
    logic [PC_W-1:0]   ex_branch_target;

    logic [DATA_W-1:0] MEM_Result;
    logic [DATA_W-1:0] MEM_StoreData;
    logic [4:0]        MEM_Rd;
    logic              MEM_Valid;
    logic              MEM_RegWrite;
    logic              MEM_FpWrite;
    logic              MEM_MemRead;
    logic              MEM_MemWrite;

    modport master (
        output EXE_Result, EXE_Zero, Overflow, ex_op, ex_valid, ex_reg_write,
               ex_fp_write, ex_mem_read, ex_mem_write, ex_trap_en, ex_rd,
               ex_store_data, ex_branch, ex_pc_plus4, ex_branch_target,
        input  MEM_Result, MEM_StoreData, MEM_Rd, MEM_Valid, MEM_RegWrite,
               MEM_FpWrite, MEM_MemRead, MEM_MemWrite
    );

    modport slave (
        input  EXE_Result, EXE_Zero, Overflow, ex_op, ex_valid, ex_reg_write,
               ex_fp_write, ex_mem_read, ex_mem_write, ex_trap_en, ex_rd,
               ex_store_data, ex_branch, ex_pc_plus4, ex_branch_target,
        output MEM_Result, MEM_StoreData, MEM_Rd, MEM_Valid, MEM_RegWrite,
               MEM_FpWrite, MEM_MemRead, MEM_MemWrite
    );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch resolve, FP condition and overflow trap
module ex_mem_stage #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            exc_ack,
    ex_mem_stage_if.slave   ex_mem,
    output logic            branch_taken,
    output logic [PC_W-1:0] branch_pc,
    output logic            fp_cond,
    output logic            exc_req,
    output logic [PC_W-1:0] epc
);
    typedef enum logic {NORMAL = 1'b0, EXC_PENDING = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [4:0]        rd_q, rd_d;
    logic              valid_q, valid_d;
    logic              rw_q, rw_d;
    logic              fw_q, fw_d;
    logic              mr_q, mr_d;
    logic              mw_q, mw_d;
    logic              bt_q, bt_d;
    logic [PC_W-1:0]   bpc_q, bpc_d;
    logic              fp_q, fp_d;
    logic [PC_W-1:0]   epc_q, epc_d;

    logic accept, trap, commit, fp_op, take;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        valid_d  = valid_q;
        rw_d     = rw_q;
        fw_d     = fw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        bt_d     = bt_q;
        bpc_d    = bpc_q;
        fp_d     = fp_q;
        epc_d    = epc_q;
        accept   = !stall && !flush && (state_q == NORMAL) && ex_mem.ex_valid;
        trap     = accept && ex_mem.ex_trap_en && ex_mem.Overflow &&
                   ((ex_mem.ex_op == 5'h03) || (ex_mem.ex_op == 5'h05));
        commit   = accept && !trap;
        fp_op    = (ex_mem.ex_op >= 5'h11) && (ex_mem.ex_op <= 5'h15);
        take     = 1'b0;
        case (ex_mem.ex_branch)
            2'b01:   take = ex_mem.EXE_Zero;
            2'b10:   take = !ex_mem.EXE_Zero;
            2'b11:   take = fp_q;
            default: take = 1'b0;
        endcase

        // A stall without flush freezes everything, including the exception state.
        if (!stall || flush) begin
            result_d = ex_mem.EXE_Result;
            store_d  = ex_mem.ex_store_data;
            rd_d     = ex_mem.ex_rd;
            valid_d  = commit;
            rw_d     = commit && ex_mem.ex_reg_write;
            fw_d     = commit && ex_mem.ex_fp_write;
            mr_d     = commit && ex_mem.ex_mem_read;
            mw_d     = commit && ex_mem.ex_mem_write;
            bt_d     = commit && take;
            if (commit && take)
                bpc_d = ex_mem.ex_branch_target;
            if (commit && fp_op)
                fp_d = ex_mem.EXE_Zero;
            if (trap) begin
                epc_d   = ex_mem.ex_pc_plus4 - PC_W'(4);
                state_d = EXC_PENDING;
            end else if ((state_q == EXC_PENDING) && exc_ack) begin
                state_d = NORMAL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= NORMAL;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
            rw_q     <= 1'b0;
            fw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            bt_q     <= 1'b0;
            bpc_q    <= '0;
            fp_q     <= 1'b0;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            valid_q  <= valid_d;
            rw_q     <= rw_d;
            fw_q     <= fw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            bt_q     <= bt_d;
            bpc_q    <= bpc_d;
            fp_q     <= fp_d;
            epc_q    <= epc_d;
        end
    end

    assign ex_mem.MEM_Result    = result_q;
    assign ex_mem.MEM_StoreData = store_q;
    assign ex_mem.MEM_Rd        = rd_q;
    assign ex_mem.MEM_Valid     = valid_q;
    assign ex_mem.MEM_RegWrite  = rw_q;
    assign ex_mem.MEM_FpWrite   = fw_q;
    assign ex_mem.MEM_MemRead   = mr_q;
    assign ex_mem.MEM_MemWrite  = mw_q;
    assign branch_taken         = bt_q;
    assign branch_pc            = bpc_q;
    assign fp_cond              = fp_q;
    assign exc_req              = (state_q == EXC_PENDING);
    assign epc                  = epc_q;
endmodule
